// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes one-hot instruction descriptors into 16-bit i281 instruction
//   words ({op, rx, ry, imm}), buffers them in a small FIFO and writes them
//   to consecutive code-memory addresses starting at 0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               pulse, opens a load session (from IDLE or DONE)
//   in_valid/in_ready   descriptor handshake
//   in_onehot/rx/ry/imm descriptor fields, in_last marks the final one
//   wr_valid/wr_ready   code-memory write handshake
//   wr_addr/wr_data     write address and encoded word
//   busy, done          session status
//   err_onehot          sticky, a descriptor without exactly one opcode bit
//   err_overflow        sticky, words beyond memory capacity were discarded
//   words_written       completed writes in the current session
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 5,
  parameter int NUM_WORDS  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [22:0]       in_onehot,
  input  logic [1:0]        in_rx,
  input  logic [1:0]        in_ry,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_onehot,
  output logic              err_overflow,
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WW_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [WW_W-1:0]   NUM_C       = WW_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;

  logic [4:0]  oh_idx;
  logic [4:0]  oh_cnt;
  logic        oh_ok;
  logic [3:0]  enc_op;
  logic [1:0]  enc_ry;
  logic [15:0] enc_word;

  logic fifo_empty, exhausted, accept, push, wr_fire, discard, pop, start_session;

  // Locate the set opcode bit and count how many bits are set; only an
  // exactly-one-hot descriptor is encoded.
  always_comb begin
    oh_idx = '0;
    oh_cnt = '0;
    for (int i = 0; i < 23; i++) begin
      if (in_onehot[i]) begin
        oh_idx = 5'(i);
        oh_cnt = oh_cnt + 5'd1;
      end
    end
    oh_ok = (oh_cnt == 5'd1);
  end

  // Opcode groups: several one-hot indices share an op and are told apart
  // by a value forced into ry (all of ry, or only ry[0] for the shifts).
  always_comb begin
    enc_op = 4'd0;
    enc_ry = in_ry;
    if (oh_idx == 5'd0) begin
      enc_op = 4'd0;
    end else if (oh_idx <= 5'd4) begin
      enc_op = 4'd1;
      enc_ry = 2'(oh_idx - 5'd1);
    end else if (oh_idx <= 5'd14) begin
      enc_op = 4'(oh_idx - 5'd3);
    end else if (oh_idx <= 5'd16) begin
      enc_op = 4'd12;
      enc_ry = {in_ry[1], (oh_idx == 5'd16)};
    end else if (oh_idx <= 5'd18) begin
      enc_op = 4'(oh_idx - 5'd4);
    end else begin
      enc_op = 4'd15;
      enc_ry = 2'(oh_idx - 5'd19);
    end
  end

  assign enc_word = {enc_op, in_rx, enc_ry, in_imm};

  assign fifo_empty    = (count == '0);
  assign exhausted     = (words_written == NUM_C);
  assign in_ready      = (state == S_LOAD) && (count < DEPTH_C);
  assign accept        = in_valid && in_ready;
  assign push          = accept && oh_ok;
  assign wr_valid      = !fifo_empty && !exhausted;
  assign wr_fire       = wr_valid && wr_ready;
  // Once memory is full the FIFO keeps draining so the session can finish.
  assign discard       = !fifo_empty && exhausted;
  assign pop           = wr_fire || discard;
  assign start_session = start && ((state == S_IDLE) || (state == S_DONE));

  // Head word is gated so the data bus reads 0 whenever no write is offered.
  assign wr_data = wr_valid ? mem[rd_ptr] : 16'h0000;
  assign wr_addr = addr;
  assign busy    = (state == S_LOAD) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (accept && in_last) state_next = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      addr          <= '0;
      words_written <= '0;
      err_onehot    <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (start_session) begin
        addr          <= '0;
        words_written <= '0;
        err_onehot    <= 1'b0;
        err_overflow  <= 1'b0;
      end else begin
        if (wr_fire) begin
          words_written <= words_written + WW_W'(1);
          // Saturate on the last address so it never wraps back to 0.
          if (addr != LAST_ADDR_C) addr <= addr + ADDR_W'(1);
        end
        if (accept && !oh_ok) err_onehot <= 1'b1;
        if (discard) err_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
//   Directed bench for instr_encoder_loader: encoding of the opcode groups,
//   write-port backpressure, FIFO full, bad one-hot descriptors, memory
//   overflow and asynchronous reset in the middle of a session.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_onehot;
  logic [1:0]  in_rx;
  logic [1:0]  in_ry;
  logic [7:0]  in_imm;
  logic        in_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err_onehot;
  logic        err_overflow;
  logic [5:0]  words_written;

  int total = 0;
  int bad   = 0;

  logic [4:0]  log_addr [$];
  logic [15:0] log_data [$];
  logic [15:0] exp_q [$];

  instr_encoder_loader #(
    .FIFO_DEPTH(4),
    .ADDR_W(5),
    .NUM_WORDS(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_onehot(in_onehot),
    .in_rx(in_rx),
    .in_ry(in_ry),
    .in_imm(in_imm),
    .in_last(in_last),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err_onehot(err_onehot),
    .err_overflow(err_overflow),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so what is seen on
  // the falling edge is exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (reset_n && wr_valid && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one descriptor and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [22:0] oh, input logic [1:0] rx, input logic [1:0] ry,
                               input logic [7:0] imm, input logic last);
    in_onehot = oh;
    in_rx     = rx;
    in_ry     = ry;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
    for (int c = 0; c < 64 && !in_ready; c++) tick();
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_onehot = '0;
  endtask

  task automatic waitDone(input string tag);
    for (int c = 0; c < 200 && !done; c++) tick();
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic startSession();
    log_addr.delete();
    log_data.delete();
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Writes must land at 0,1,2,... with the expected words in order.
  task automatic checkLog(input string tag);
    checkOutput({tag, "_count"}, 32'(log_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput({tag, "_addr"}, (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hFFFF, 32'(i));
      checkOutput({tag, "_data"}, (i < log_data.size()) ? 32'(log_data[i]) : 32'hFFFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_onehot = '0;
    in_rx     = '0;
    in_ry     = '0;
    in_imm    = '0;
    in_last   = 1'b0;
    wr_ready  = 1'b0;
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err_onehot", 32'(err_onehot), 32'd0);
    checkOutput("rst_err_overflow", 32'(err_overflow), 32'd0);
    checkOutput("rst_words", 32'(words_written), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

    $display("[TB] single ADD");
    wr_ready = 1'b1;
    startSession();
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_in_ready", 32'(in_ready), 32'd1);
    checkOutput("pre_accept_wr_valid", 32'(wr_valid), 32'd0);
    exp_q.push_back(16'h4600);
    applyStimulus(23'h1 << 7, 2'd1, 2'd2, 8'h00, 1'b1);
    checkOutput("add_wr_valid", 32'(wr_valid), 32'd1);
    checkOutput("add_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("add_wr_data", 32'(wr_data), 32'h4600);
    waitDone("add_done");
    checkOutput("add_words", 32'(words_written), 32'd1);
    checkOutput("add_busy", 32'(busy), 32'd0);
    checkLog("add_log");

    $display("[TB] INPUTDF and SHIFTR");
    startSession();
    checkOutput("restart_done", 32'(done), 32'd0);
    exp_q.push_back(16'h1B10);
    exp_q.push_back(16'hCF00);
    applyStimulus(23'h1 << 4, 2'd2, 2'd0, 8'h10, 1'b0);
    applyStimulus(23'h1 << 16, 2'd3, 2'd2, 8'h00, 1'b1);
    waitDone("enc_done");
    checkOutput("enc_words", 32'(words_written), 32'd2);
    checkLog("enc_log");

    $display("[TB] BRGE with write backpressure");
    wr_ready = 1'b0;
    startSession();
    exp_q.push_back(16'hF3F3);
    applyStimulus(23'h1 << 22, 2'd0, 2'd0, 8'hF3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_wr_valid", 32'(wr_valid), 32'd1);
      checkOutput("hold_wr_data", 32'(wr_data), 32'hF3F3);
      checkOutput("hold_wr_addr", 32'(wr_addr), 32'd0);
      tick();
    end
    checkOutput("hold_no_write", 32'(log_data.size()), 32'd0);
    wr_ready = 1'b1;
    waitDone("hold_done");
    checkOutput("hold_words", 32'(words_written), 32'd1);
    checkLog("hold_log");

    $display("[TB] burst of 6 against a full FIFO");
    wr_ready = 1'b0;
    startSession();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({4'(i + 2), 2'b01, 2'b10, 8'(8'h10 + i)});
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(23'h1 << (5 + i), 2'd1, 2'd2, 8'(8'h10 + i), 1'b0);
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_no_write", 32'(log_data.size()), 32'd0);
    wr_ready = 1'b1;
    applyStimulus(23'h1 << 9, 2'd1, 2'd2, 8'h14, 1'b0);
    applyStimulus(23'h1 << 10, 2'd1, 2'd2, 8'h15, 1'b1);
    waitDone("burst_done");
    checkOutput("burst_words", 32'(words_written), 32'd6);
    checkLog("burst_log");

    $display("[TB] bad one-hot 0x000003");
    startSession();
    checkOutput("err_cleared", 32'(err_onehot), 32'd0);
    exp_q.push_back(16'h05AA);
    exp_q.push_back(16'h6B55);
    applyStimulus(23'h1, 2'd1, 2'd1, 8'hAA, 1'b0);
    applyStimulus(23'h3, 2'd3, 2'd3, 8'hFF, 1'b0);
    applyStimulus(23'h1 << 9, 2'd2, 2'd3, 8'h55, 1'b1);
    waitDone("bad3_done");
    checkOutput("bad3_err", 32'(err_onehot), 32'd1);
    checkOutput("bad3_words", 32'(words_written), 32'd2);
    checkLog("bad3_log");

    $display("[TB] bad one-hot 0 with shift, op13 and op15 groups");
    startSession();
    checkOutput("err_recleared", 32'(err_onehot), 32'd0);
    exp_q.push_back(16'hC201);
    exp_q.push_back(16'hD500);
    exp_q.push_back(16'hFC07);
    applyStimulus(23'h1 << 15, 2'd0, 2'd3, 8'h01, 1'b0);
    applyStimulus(23'h0, 2'd1, 2'd1, 8'h11, 1'b0);
    applyStimulus(23'h1 << 17, 2'd1, 2'd1, 8'h00, 1'b0);
    applyStimulus(23'h1 << 19, 2'd3, 2'd2, 8'h07, 1'b1);
    waitDone("bad0_done");
    checkOutput("bad0_err", 32'(err_onehot), 32'd1);
    checkOutput("bad0_words", 32'(words_written), 32'd3);
    checkLog("bad0_log");

    $display("[TB] 33 descriptors into 32 words");
    startSession();
    for (int i = 0; i < 32; i++) exp_q.push_back(16'h4600 | 16'(i));
    for (int i = 0; i < 33; i++) begin
      applyStimulus(23'h1 << 7, 2'd1, 2'd2, 8'(i), (i == 32));
    end
    waitDone("ovf_done");
    checkOutput("ovf_err", 32'(err_overflow), 32'd1);
    checkOutput("ovf_err_onehot", 32'(err_onehot), 32'd0);
    checkOutput("ovf_words", 32'(words_written), 32'd32);
    checkOutput("ovf_wr_valid", 32'(wr_valid), 32'd0);
    checkLog("ovf_log");

    $display("[TB] reset in the middle of a burst");
    wr_ready = 1'b0;
    startSession();
    checkOutput("mid_ovf_cleared", 32'(err_overflow), 32'd0);
    applyStimulus(23'h1 << 7, 2'd1, 2'd2, 8'h01, 1'b0);
    applyStimulus(23'h1 << 8, 2'd1, 2'd2, 8'h02, 1'b0);
    checkOutput("mid_wr_valid_before", 32'(wr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("mid_wr_data", 32'(wr_data), 32'd0);
    checkOutput("mid_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_done", 32'(done), 32'd0);
    checkOutput("mid_words", 32'(words_written), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd0);
    checkOutput("post_done", 32'(done), 32'd0);
    startSession();
    checkOutput("post_start_busy", 32'(busy), 32'd1);
    checkOutput("post_start_wr_valid", 32'(wr_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the opcode decoder. Accepts one-hot instruction descriptors (23-bit one-hot opcode, RX, RY, 8-bit immediate) and encodes each into a 16-bit i281 instruction word.
- Buffers encoded words in a small FIFO and writes them to sequential code-memory addresses through a valid/ready write port.
- Used to load programs into the multicycle core's instruction memory from a host or test harness.

Parameters:
- FIFO_DEPTH, 4: encoded-word FIFO entries (power of 2, at least 2).
- ADDR_W, 5: code-memory address width.
- NUM_WORDS, 32: code-memory capacity in words (at most 2^ADDR_W).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load session from address 0.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_onehot  in  23  one-hot opcode; bit numbering matches the decoder's opcode_out[22:0].
- in_rx  in  2  RX field.
- in_ry  in  2  RY field.
- in_imm  in  8  immediate/address byte.
- in_last  in  1  marks the final descriptor of the session.
- wr_valid  out  1  code-memory write request.
- wr_ready  in  1  code-memory accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  16  encoded instruction.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- err_onehot  out  1  sticky: a descriptor with popcount(in_onehot) != 1 was seen.
- err_overflow  out  1  sticky: more than NUM_WORDS valid words were produced.
- words_written  out  ADDR_W+1  count of completed writes this session.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; FIFO emptied; write address 0.
  - All outputs 0: in_ready, wr_valid, wr_addr, wr_data, busy, done, err_*, words_written.
- Encoding. Output word is {op[3:0], rx[1:0], ry[1:0], imm[7:0]}. For one-hot index k:
  - k=0: op=0; rx, ry pass through.
  - k=1..4: op=1; ry forced to k-1.
  - k=5..14: op=k-3; rx, ry pass through.
  - k=15,16: op=12; ry[1]=in_ry[1], ry[0] forced to k-15.
  - k=17,18: op=k-4 (13, 14); rx, ry pass through.
  - k=19..22: op=15; ry forced to k-19.
- States:
  - IDLE: in_ready=0. start moves to LOAD, clears address, words_written, err_onehot and err_overflow.
  - LOAD: in_ready = (FIFO count < FIFO_DEPTH); no same-cycle bypass.
    - Valid descriptor: encoded and pushed.
    - Invalid one-hot: consumed and not pushed; err_onehot set.
    - Accepted in_last (valid or not) moves to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, move to DONE.
  - DONE: done=1 and held. start returns to LOAD with a fresh session (as from IDLE).
  - start while in LOAD or DRAIN is ignored.
- Latency: a descriptor accepted at edge N appears on wr_valid/wr_data from cycle N+1 if the FIFO was empty.
- Write port:
  - wr_valid = FIFO not empty && address not exhausted.
  - wr_addr, wr_data and wr_valid are stable while wr_valid && !wr_ready.
  - On a transfer: pop, address+1, words_written+1.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Overflow: once words_written == NUM_WORDS, every remaining FIFO entry (and any later pushed word) is popped without a write. err_overflow is set and wr_valid stays 0.
- Address wrap never occurs; overflow handling prevents it.
- Reset asserted mid-session aborts immediately to the reset state. Partial writes already made stand.

Test Plan:
- ADD (index 7), rx=1, ry=2, imm=0x00, in_last=1 -> one write: addr 0, data 0x4600, first wr_valid one cycle after acceptance; then done=1, words_written=1.
- INPUTDF (index 4), rx=2, ry=0, imm=0x10 -> data 0x1B10 (ry forced to 3). SHIFTR (index 16), rx=3, ry=2, imm=0 -> data 0xCF00.
- BRGE (index 22), rx=0, imm=0xF3, with wr_ready held low 5 cycles -> wr_data 0xF3F3 and wr_addr stable for 5 cycles; single write on release.
- Burst of 6 descriptors, wr_ready=0 -> in_ready drops after 4 accepted; raise wr_ready -> addresses 0..5 written in order, no loss, no duplicates.
- Descriptor with onehot 0x000003 between two valid ones -> err_onehot=1, only 2 writes (addr 0, 1); onehot 0 behaves the same.
- 33 valid descriptors -> 32 writes (addr 0..31), err_overflow=1, done reached. Reset asserted mid-burst -> all outputs 0 within the same cycle; IDLE held until start.
